// File: rtl/uart_pkg.sv
// Shared UART definitions: baud defaults, transmitter state encoding and status register layout.
package uart_pkg;

    localparam int unsigned CLOCK_DIVISOR_DEFAULT = 4618;
    localparam int unsigned DATA_BITS             = 8;
    localparam int unsigned BAUD_CNT_W            = 13;
    localparam int unsigned BIT_IDX_W             = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned STAT_RX_READY   = 0;
    localparam int unsigned STAT_TX_EMPTY   = 1;
    localparam int unsigned STAT_TX_BUSY    = 2;
    localparam int unsigned STAT_TX_OVERRUN = 3;

    typedef struct packed {
        logic tx_overrun;
        logic tx_busy;
        logic tx_empty;
        logic rx_ready;
    } uart_status_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running divider with synchronous enable and clear.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR = CLOCK_DIVISOR_DEFAULT,
    parameter int unsigned CNT_W   = BAUD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_top;

    assign at_top   = (cnt_q == CNT_W'(DIVISOR - 1));
    assign tick_c_o = en_i & ~clr_i & at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter with a one-entry holding register in front of the shifter,
// giving back-to-back frames, sticky overrun status and an active-low empty interrupt.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_DIVISOR = CLOCK_DIVISOR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_load,
    input  logic                 i_irq_en,
    input  logic                 i_status_clr,
    output logic                 o_UART_RX,
    output logic                 o_tx_busy,
    output logic                 o_tx_empty,
    output logic                 o_tx_overrun,
    output logic                 o_IRQ
);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_BITS-1:0]   hr_q, hr_d;
    logic                   hr_empty_q, hr_empty_d;
    logic                   overrun_q, overrun_d;
    logic                   line_q, line_d;
    logic                   busy_q, busy_d;
    logic                   irq_q, irq_d;
    logic                   xfer;
    logic                   baud_tick_c;

    uart_baud_gen #(
        .DIVISOR (CLOCK_DIVISOR),
        .CNT_W   (BAUD_CNT_W)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q != TX_IDLE),
        .clr_i    (state_q == TX_IDLE),
        .tick_c_o (baud_tick_c)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        hr_d       = hr_q;
        hr_empty_d = hr_empty_q;
        overrun_d  = overrun_q;
        xfer       = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                if (!hr_empty_q) begin
                    xfer    = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick_c) begin
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_tick_c) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + BIT_IDX_W'(1);
                    if (idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (baud_tick_c) begin
                    if (!hr_empty_q) begin
                        xfer    = 1'b1;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (xfer) begin
            shift_d    = hr_q;
            hr_empty_d = 1'b1;
        end

        // A load coinciding with the transfer refills the register the transfer just freed.
        if (i_tx_load && (hr_empty_q || xfer)) begin
            hr_d       = i_tx_data;
            hr_empty_d = 1'b0;
        end

        if (i_tx_load && !hr_empty_q && !xfer) begin
            overrun_d = 1'b1;
        end else if (i_status_clr) begin
            overrun_d = 1'b0;
        end

        unique case (state_d)
            TX_START: line_d = 1'b0;
            TX_DATA:  line_d = shift_d[0];
            default:  line_d = 1'b1;
        endcase

        busy_d = (state_d != TX_IDLE);
        irq_d  = ~(i_irq_en & hr_empty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            hr_q       <= '0;
            hr_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            hr_q       <= hr_d;
            hr_empty_q <= hr_empty_d;
            overrun_q  <= overrun_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    assign o_UART_RX    = line_q;
    assign o_tx_busy    = busy_q;
    assign o_tx_empty   = hr_empty_q;
    assign o_tx_overrun = overrun_q;
    assign o_IRQ        = irq_q;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Serial UART transmitter, 8N1, that sends bytes written by the 6809 host interface out on the FT2232 RX line. It takes a byte through a load strobe, buffers it in a 1-entry holding register, and serializes it LSB-first at the configured baud rate. It reports status to the UART status register and drives an active-low "transmit empty" interrupt. It sits beside the existing UART receive path in the same UART interface region.

Parameters:
CLOCK_DIVISOR, 4618, system clocks per bit period (44.33 MHz / 9600 bps); legal range 2..8191
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision

Ports:
clk  input  1  system clock, 44.33 MHz
reset  input  1  asynchronous, active-high reset
i_tx_data  input  8  byte from 6809 data register
i_tx_load  input  1  one-clk strobe: write i_tx_data into the holding register
i_irq_en  input  1  transmit-empty interrupt enable (control register bit)
o_UART_RX  output  1  serial line to FT2232 RX; idle high
o_tx_busy  output  1  shifter is sending a frame
o_tx_empty  output  1  holding register is empty and can accept a byte
o_tx_overrun  output  1  sticky: load was attempted while holding register was full
i_status_clr  input  1  one-clk strobe: clear o_tx_overrun
o_IRQ  output  1  active-low; low when i_irq_en=1 and o_tx_empty=1

Behaviour:
- Single clock domain (clk) only. No derived or gated baud clock. The baud tick is a 13-bit counter that pulses for 1 clk when counter==CLOCK_DIVISOR-1, then wraps to 0.
- The baud counter is held at 0 while in IDLE. It starts counting when the START state is entered, so the start bit lasts exactly CLOCK_DIVISOR clks.
- Reset values: o_UART_RX=1, o_tx_busy=0, o_tx_empty=1, o_tx_overrun=0, o_IRQ=1. The FSM is in IDLE, the counters are 0, and the holding register is 0.
- Holding register (HR): i_tx_load with HR empty latches the data and sets empty=0 on the next clk.
- i_tx_load while HR is full: the data is dropped, the HR is unchanged, and o_tx_overrun=1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: line=1. If HR is full, copy HR to the shift register, set HR empty, go to START, set busy=1. Latency from load in IDLE to the line falling is 2 clks (1 clk to latch HR, 1 clk to transfer).
- START: line=0 for one bit period, then go to DATA with bit index=0.
- DATA: line=shift[0]. On each tick, shift right and increment the index. After the tick at index 7, go to STOP.
- STOP: line=1 for one bit period. On the tick, there are two cases:
  - HR full: transfer the next byte and go directly to START. There is no extra idle time, so frames are back-to-back with exactly 1 stop bit.
  - HR empty: go to IDLE and set busy=0.
- Frame length is exactly 10*CLOCK_DIVISOR clks.
- A load in the same clk as the HR-to-shifter transfer is accepted: the HR is refilled and overrun is not set. A full HR is cleared by the transfer and filled by the load in that same cycle.
- i_status_clr and an overrun event in the same clk: the set wins.
- o_IRQ is registered: o_IRQ = ~(i_irq_en & o_tx_empty), 1 clk latency.
- Reset asserted mid-frame: the line goes high immediately (asynchronous), the frame is aborted, and the HR is flushed. There is no partial resume.
- Loads during busy are legal as long as the HR is empty. This gives a double buffer: the HR plus the shifter.

Decomposition:
- Shared package uart_pkg:
  - CLOCK_DIVISOR default
  - FSM state encoding localparams (IDLE/START/DATA/STOP, 2 bits)
  - status bit positions: bit0 rx_ready, bit1 tx_empty, bit2 tx_busy, bit3 tx_overrun
- Sub-module uart_baud_gen: counter with sync enable/clear, tick output. Reusable later by a reworked receiver using 16x oversampling.

Test Plan:
1. Reset, then load 0x55 with irq_en=0 → after 2 clks, line=0 for 4618 clks. Data bits 1,0,1,0,1,0,1,0 at 4618 clks each, then stop=1. busy deasserts at 46180+2 clks; o_IRQ stays 1.
2. Load 0xA3, then load 0x0F during the start bit of 0xA3 → two back-to-back frames with no gap between the 0xA3 stop bit and the 0x0F start bit; overrun=0.
3. Load three bytes within 3 clks while idle → the first two are transmitted; the third sets overrun=1. i_status_clr later clears it. clr and overrun in the same clk → overrun=1.
4. irq_en=1 at idle → o_IRQ=0. Load a byte → o_IRQ=1 one clk after empty falls. It returns to 0 one clk after the HR transfers to the shifter.
5. Assert reset in the middle of data bit 4 of 0xFF → line goes to 1 immediately. All outputs return to reset values, and no further bits appear after reset is released.
6. CLOCK_DIVISOR=2 build → a load of 0x81 gives a 20-clk frame with the exact bit pattern 0,1,0,0,0,0,0,0,1,1.
